// File: rtl/mcu_cmd_rx.sv
// rtl/mcu_cmd_rx.sv - MCU SPI command receiver: oversampled framing, byte validation, command FIFO
module mcu_cmd_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_sdi,
    input  logic       spi_cs_n,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    input  logic       cmd_ready,
    output logic       overflow,
    output logic [7:0] bad_frame_count,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   armed;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   cs_n_s;
    logic                   sck_rise;

    state_t      state;
    state_t      state_d;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_d;
    logic [2:0]  bit_cnt;
    logic [2:0]  cnt_d;
    logic        push_req;
    logic        bad_inc;
    logic        byte_ok;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic [CW-1:0] remain;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;
    logic [1:0]    push_data;
    logic [1:0]    head_d;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign cs_n_s   = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign busy     = ~cs_n_s;

    // fill marks when the synchronizer output reflects real samples rather than
    // reset values; armed then requires a genuine cs_n high before a frame can start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_sync  <= '1;
            fill     <= '0;
            sck_prev <= 1'b0;
            cs_prev  <= 1'b1;
            armed    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            sck_prev <= sck_s;
            cs_prev  <= cs_n_s;
            armed    <= armed | (fill[SYNC_STAGES-1] & cs_n_s);
        end
    end

    assign byte_ok   = (shift_reg[7:4] == 4'hA) && (shift_reg[3:2] == 2'b00);
    assign push_data = shift_reg[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_d;
            shift_reg <= shift_d;
            bit_cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        shift_d  = shift_reg;
        cnt_d    = bit_cnt;
        push_req = 1'b0;
        bad_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (armed && cs_prev && !cs_n_s) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cs_n_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (sck_rise) begin
                    shift_d = {shift_reg[6:0], sdi_s};
                    if (bit_cnt == 3'd7) begin
                        cnt_d   = '0;
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            S_CHECK: begin
                if (byte_ok) begin
                    push_req = 1'b1;
                end else begin
                    bad_inc = 1'b1;
                end
                state_d = cs_n_s ? S_IDLE : S_SHIFT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Head register is refilled from the entry behind it, or straight from the
    // incoming push when the queue would otherwise be empty after this cycle.
    always_comb begin
        pop      = cmd_valid & cmd_ready;
        full     = (count == CW'(FIFO_DEPTH));
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        rd_ptr_d = rd_ptr + AW'(pop);
        count_d  = count + CW'(push) - CW'(pop);
        remain   = count - CW'(pop);
        head_d   = cmd;
        if (count_d != '0) begin
            head_d = (remain == '0) ? push_data : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            cmd             <= 2'd0;
            cmd_valid       <= 1'b0;
            overflow        <= 1'b0;
            bad_frame_count <= '0;
        end else begin
            rd_ptr    <= rd_ptr_d;
            count     <= count_d;
            cmd       <= head_d;
            cmd_valid <= (count_d != '0);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (bad_inc && (bad_frame_count != 8'hFF)) begin
                bad_frame_count <= bad_frame_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_mcu_cmd_rx.sv
// tb/tb_mcu_cmd_rx.sv - directed self-checking bench for mcu_cmd_rx
module tb_mcu_cmd_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck;
    logic       spi_sdi;
    logic       spi_cs_n;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       overflow;
    logic [7:0] bad_frame_count;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    mcu_cmd_rx dut (
        .clk             (clk),
        .reset           (reset),
        .spi_sck         (spi_sck),
        .spi_sdi         (spi_sdi),
        .spi_cs_n        (spi_cs_n),
        .cmd_valid       (cmd_valid),
        .cmd             (cmd),
        .cmd_ready       (cmd_ready),
        .overflow        (overflow),
        .bad_frame_count (bad_frame_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset;
        reset = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0; spi_cs_n = 1'b1; cmd_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_sdi = b[7-i];
            tick(3);
            spi_sck = 1'b1;
            tick(3);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame_start;
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end;
        tick(3);
        spi_cs_n = 1'b1;
        tick(4);
    endtask

    task automatic test_reset;
        reset = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0; spi_cs_n = 1'b1; cmd_ready = 1'b0;
        tick(2);
        if (cmd_valid !== 1'b0) begin $display("FAIL rst_valid got=%0h exp=0", cmd_valid); n_bad++; end
        n_total++;
        if (cmd !== 2'd0) begin $display("FAIL rst_cmd got=%0h exp=0", cmd); n_bad++; end
        n_total++;
        if (overflow !== 1'b0) begin $display("FAIL rst_overflow got=%0h exp=0", overflow); n_bad++; end
        n_total++;
        if (bad_frame_count !== 8'd0) begin $display("FAIL rst_bad_count got=%0d exp=0", bad_frame_count); n_bad++; end
        n_total++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy got=%0h exp=0", busy); n_bad++; end
        n_total++;
        reset = 1'b0;
        tick(4);
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL idle_after_rst got valid=%0h busy=%0h exp 0 0", cmd_valid, busy); n_bad++;
        end
        n_total++;
    endtask

    task automatic test_latency;
        cmd_ready = 1'b1;
        frame_start;
        send_bits(8'hA3, 7);
        spi_sdi = 1'b1;
        tick(3);
        spi_sck = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            if (cmd_valid !== 1'b0) begin $display("FAIL lat_early cycle=%0d got=%0h exp=0", k, cmd_valid); n_bad++; end
            n_total++;
        end
        tick(1);
        if (cmd_valid !== 1'b1 || cmd !== 2'd3) begin
            $display("FAIL lat_valid got valid=%0h cmd=%0h exp 1 3", cmd_valid, cmd); n_bad++;
        end
        n_total++;
        tick(1);
        if (cmd_valid !== 1'b0 || cmd !== 2'd3) begin
            $display("FAIL lat_one_cycle got valid=%0h cmd=%0h exp 0 3", cmd_valid, cmd); n_bad++;
        end
        n_total++;
        spi_sck = 1'b0;
        frame_end;
        cmd_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_cmd [3] = '{2'd2, 2'd1, 2'd0};
        cmd_ready = 1'b0;
        frame_start;
        if (busy !== 1'b1) begin $display("FAIL b2b_busy got=%0h exp=1", busy); n_bad++; end
        n_total++;
        send_bits(8'hA2, 8);
        send_bits(8'hA1, 8);
        send_bits(8'hA0, 8);
        frame_end;
        cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cmd_valid !== 1'b1 || cmd !== exp_cmd[i]) begin
                $display("FAIL b2b_order idx=%0d got valid=%0h cmd=%0h exp 1 %0h", i, cmd_valid, cmd, exp_cmd[i]); n_bad++;
            end
            n_total++;
            tick(1);
        end
        if (cmd_valid !== 1'b0 || cmd !== 2'd0) begin
            $display("FAIL b2b_empty got valid=%0h cmd=%0h exp 0 0", cmd_valid, cmd); n_bad++;
        end
        n_total++;
        cmd_ready = 1'b0;
    endtask

    task automatic test_overflow;
        logic [7:0] bytes [6] = '{8'hA2, 8'hA3, 8'hA1, 8'hA0, 8'hA1, 8'hA2};
        logic [1:0] exp_cmd [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        cmd_ready = 1'b0;
        frame_start;
        for (int i = 0; i < 6; i++) send_bits(bytes[i], 8);
        frame_end;
        if (overflow !== 1'b1) begin $display("FAIL ovf_flag got=%0h exp=1", overflow); n_bad++; end
        n_total++;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cmd_valid !== 1'b1 || cmd !== exp_cmd[i]) begin
                $display("FAIL ovf_drain idx=%0d got valid=%0h cmd=%0h exp 1 %0h", i, cmd_valid, cmd, exp_cmd[i]); n_bad++;
            end
            n_total++;
            tick(1);
        end
        if (cmd_valid !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL ovf_after_drain got valid=%0h ovf=%0h exp 0 1", cmd_valid, overflow); n_bad++;
        end
        n_total++;
        cmd_ready = 1'b0;
    endtask

    task automatic test_bad_bytes;
        apply_reset;
        frame_start;
        send_bits(8'h53, 8);
        send_bits(8'hA7, 8);
        frame_end;
        if (bad_frame_count !== 8'd2 || cmd_valid !== 1'b0) begin
            $display("FAIL bad_two got count=%0d valid=%0h exp 2 0", bad_frame_count, cmd_valid); n_bad++;
        end
        n_total++;
        frame_start;
        repeat (252) send_bits(8'h00, 8);
        frame_end;
        if (bad_frame_count !== 8'd254) begin $display("FAIL bad_254 got=%0d exp=254", bad_frame_count); n_bad++; end
        n_total++;
        frame_start;
        send_bits(8'hB1, 8);
        frame_end;
        if (bad_frame_count !== 8'd255) begin $display("FAIL bad_255 got=%0d exp=255", bad_frame_count); n_bad++; end
        n_total++;
        frame_start;
        repeat (45) send_bits(8'hFF, 8);
        frame_end;
        if (bad_frame_count !== 8'd255 || cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL bad_saturate got count=%0d valid=%0h ovf=%0h exp 255 0 0", bad_frame_count, cmd_valid, overflow); n_bad++;
        end
        n_total++;
    endtask

    task automatic test_partial;
        apply_reset;
        frame_start;
        send_bits(8'hA1, 5);
        tick(3);
        spi_cs_n = 1'b1;
        tick(4);
        frame_start;
        send_bits(8'hA1, 8);
        frame_end;
        if (cmd_valid !== 1'b1 || cmd !== 2'd1 || bad_frame_count !== 8'd0) begin
            $display("FAIL partial got valid=%0h cmd=%0h count=%0d exp 1 1 0", cmd_valid, cmd, bad_frame_count); n_bad++;
        end
        n_total++;
        cmd_ready = 1'b1;
        tick(1);
        if (cmd_valid !== 1'b0) begin $display("FAIL partial_single got=%0h exp=0", cmd_valid); n_bad++; end
        n_total++;
        cmd_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        logic [1:0] exp_cmd [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        apply_reset;
        frame_start;
        send_bits(8'hA0, 8);
        send_bits(8'hA1, 8);
        send_bits(8'hA2, 8);
        send_bits(8'hA3, 8);
        send_bits(8'hA1, 7);
        spi_sdi = 1'b1;
        tick(3);
        spi_sck = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        spi_sck = 1'b0;
        if (overflow !== 1'b0 || cmd_valid !== 1'b1 || cmd !== 2'd1) begin
            $display("FAIL fpp_accept got ovf=%0h valid=%0h cmd=%0h exp 0 1 1", overflow, cmd_valid, cmd); n_bad++;
        end
        n_total++;
        frame_end;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cmd_valid !== 1'b1 || cmd !== exp_cmd[i]) begin
                $display("FAIL fpp_order idx=%0d got valid=%0h cmd=%0h exp 1 %0h", i, cmd_valid, cmd, exp_cmd[i]); n_bad++;
            end
            n_total++;
            tick(1);
        end
        if (cmd_valid !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL fpp_empty got valid=%0h ovf=%0h exp 0 0", cmd_valid, overflow); n_bad++;
        end
        n_total++;
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_byte;
        cmd_ready = 1'b0;
        frame_start;
        send_bits(8'h00, 8);
        send_bits(8'hA2, 8);
        send_bits(8'hA3, 4);
        reset = 1'b1;
        tick(2);
        if (cmd_valid !== 1'b0 || cmd !== 2'd0 || overflow !== 1'b0 || bad_frame_count !== 8'd0 || busy !== 1'b0) begin
            $display("FAIL midrst_outputs got valid=%0h cmd=%0h ovf=%0h count=%0d busy=%0h exp all 0",
                     cmd_valid, cmd, overflow, bad_frame_count, busy); n_bad++;
        end
        n_total++;
        reset = 1'b0;
        tick(4);
        if (busy !== 1'b1) begin $display("FAIL midrst_busy got=%0h exp=1", busy); n_bad++; end
        n_total++;
        send_bits(8'hA3, 4);
        send_bits(8'hA2, 8);
        tick(6);
        if (cmd_valid !== 1'b0 || bad_frame_count !== 8'd0) begin
            $display("FAIL midrst_ignored got valid=%0h count=%0d exp 0 0", cmd_valid, bad_frame_count); n_bad++;
        end
        n_total++;
        spi_cs_n = 1'b1;
        tick(4);
        frame_start;
        send_bits(8'hA2, 8);
        frame_end;
        if (cmd_valid !== 1'b1 || cmd !== 2'd2) begin
            $display("FAIL midrst_fresh got valid=%0h cmd=%0h exp 1 2", cmd_valid, cmd); n_bad++;
        end
        n_total++;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_back_to_back;
        test_overflow;
        test_bad_bytes;
        test_partial;
        test_full_push_pop;
        test_reset_mid_byte;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
